sa_weight_skewer: RTL and testbench

Upstream feeder for the systolic-array MAC core. It accepts one weight vector (PE_SIZE lanes) per beat over a valid/ready handshake. It applies the triangular skew the array needs: lane k is delayed k cycles relative to lane 0. It drives the array's weight column bus and per-lane weight enables, and signals tile completion once the last beat has fully entered the array.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_skew_line.sv | 50 +++++
 rtl/sa_weight_skewer.sv | 167 ++++++++++++++++
 tb/tb_sa_weight_skewer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Purpose: shared definitions for the systolic-array edge blocks (state enum, lane slicing, counter width).
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sa_pkg;

    // Control states shared by the array-edge feeders.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } sa_state_e;

    // Width of the per-tile beat counters exported by the feeders.
    localparam int BEAT_CNT_W = 16;

    // MSB of lane k in a packed lane vector. Lane 0 occupies the top slice,
    // so higher lane indices move toward bit 0.
    function automatic int lane_msb(input int k, input int pe_size, input int data_width);
        return data_width * (pe_size - k) - 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Purpose: fixed-depth shift register used as one lane of the weight skew triangle.
// Latency: DEPTH cycles from in_i to out_o.
// Backpressure: none; shifts every cycle. clear_i zeroes every stage at the next edge.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   clear_i     - synchronous flush of all stages
//   in_i        - word entering stage 0
//   out_o       - word leaving the last stage
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = '0;
        end
        if (!clear_i) begin
            stage_d[0] = in_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_weight_skewer.sv
// Purpose: accepts weight vectors and skews them so lane k reaches the array k cycles after lane 0.
// Latency: lane 0 one cycle after accept, lane PE_SIZE-1 PE_SIZE cycles after accept; done_o with the last lane.
// Backpressure: in_ready_o drops while the last beat of a tile drains through the upper lanes, and during clear_i.
//
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   clear_i           - synchronous flush of FSM, counters and skew lines (highest priority)
//   in_valid_i/in_ready_o/in_data_i/in_last_i - weight beat handshake, lane 0 in the MSBs
//   weight_col_o      - skewed weights, same lane packing as in_data_i
//   weight_en_col_o   - per-lane enable, lane k at bit PE_SIZE-1-k
//   busy_o            - tile in progress (state not IDLE)
//   done_o            - one-cycle pulse when the last lane of the last beat is on the bus
//   beat_cnt_o        - beats accepted in the current tile, saturating
module sa_weight_skewer
    import sa_pkg::*;
#(
    parameter int PE_SIZE    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] in_data_i,
    input  logic                          in_last_i,
    output logic [DATA_WIDTH*PE_SIZE-1:0] weight_col_o,
    output logic [PE_SIZE-1:0]            weight_en_col_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [BEAT_CNT_W-1:0]         beat_cnt_o
);

    // The drain counter only needs to reach PE_SIZE-2; keep it at least one bit wide.
    localparam int DCW = (PE_SIZE > 2) ? $clog2(PE_SIZE) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = (PE_SIZE >= 2) ? DCW'(PE_SIZE - 2) : '0;
    localparam bit SINGLE_LANE = (PE_SIZE == 1);
    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = {BEAT_CNT_W{1'b1}};

    sa_state_e             state_q,     state_d;
    logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic                  done_q,      done_d;

    logic accept;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready_o = (state_q != DRAIN) && !clear_i;
    assign accept     = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Control FSM: next state, drain counter, beat counter, done pulse
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;

        if (clear_i) begin
            state_d     = IDLE;
            drain_cnt_d = '0;
            beat_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // First beat of a new tile restarts the count.
                        beat_cnt_d = BEAT_CNT_W'(1);
                        if (!in_last_i) begin
                            state_d = STREAM;
                        end else if (SINGLE_LANE) begin
                            // One lane: the beat is fully on the bus next cycle.
                            done_d = 1'b1;
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end
                    end
                end

                STREAM: begin
                    if (accept) begin
                        if (beat_cnt_q != BEAT_CNT_MAX) begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                        if (in_last_i) begin
                            if (SINGLE_LANE) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d     = DRAIN;
                                drain_cnt_d = '0;
                            end
                        end
                    end
                end

                DRAIN: begin
                    // The last beat was accepted on entry; its top lane is on
                    // the bus PE_SIZE-1 edges later, which is when counting
                    // from 0 reaches DRAIN_LAST and the next edge fires.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign beat_cnt_o = beat_cnt_q;

    // ------------------------------------------------------------------
    // Skew triangle: lane k rides a (k+1)-deep line carrying {valid, data}.
    // Non-accept cycles push an all-zero word, so bubbles travel with the
    // beats and every lane sees the gap shifted by its own index.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
        localparam int MSB = lane_msb(k, PE_SIZE, DATA_WIDTH);

        logic [DATA_WIDTH:0] lane_in;
        logic [DATA_WIDTH:0] lane_out;

        assign lane_in = accept ? {1'b1, in_data_i[MSB -: DATA_WIDTH]} : '0;

        sa_skew_line #(
            .DEPTH (k + 1),
            .WIDTH (DATA_WIDTH + 1)
        ) u_skew_line (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (clear_i),
            .in_i    (lane_in),
            .out_o   (lane_out)
        );

        // Data is masked by the enable so the array never sees stale weights.
        assign weight_en_col_o[PE_SIZE-1-k]   = lane_out[DATA_WIDTH];
        assign weight_col_o[MSB -: DATA_WIDTH] = lane_out[DATA_WIDTH] ? lane_out[DATA_WIDTH-1:0] : '0;
    end

endmodule

// File: tb/tb_sa_weight_skewer.sv
// Purpose: self-checking bench for sa_weight_skewer against a beat-history reference model.
// Latency: n/a.
// Backpressure: bench honours in_ready_o through the model's own ready prediction.
module tb_sa_weight_skewer;

    localparam int PE = 4;
    localparam int DW = 8;
    localparam int VW = PE * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [VW-1:0] in_data_i;
    logic          in_last_i;
    logic [VW-1:0] weight_col_o;
    logic [PE-1:0] weight_en_col_o;
    logic          busy_o;
    logic          done_o;
    logic [15:0]   beat_cnt_o;

    always #5 clk = ~clk;

    sa_weight_skewer #(.PE_SIZE(PE), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (clear_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_data_i       (in_data_i),
        .in_last_i       (in_last_i),
        .weight_col_o    (weight_col_o),
        .weight_en_col_o (weight_en_col_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .beat_cnt_o      (beat_cnt_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: hv/hd[k] is the beat accepted k edges ago (lane k shows its slice).
    logic          hv [PE];
    logic [VW-1:0] hd [PE];
    int            edge_n    = 0;
    int            last_edge = 0;
    bit            last_pend, tile_open, m_done, m_ready, m_acc, exp_busy;
    int            m_cnt;
    logic          obs_ready;
    logic [VW-1:0] exp_col;
    logic [PE-1:0] exp_en;

    function automatic void model_outputs();
        exp_col = '0;
        exp_en  = '0;
        for (int k = 0; k < PE; k++) begin
            if (hv[k]) begin
                exp_en[PE-1-k] = 1'b1;
                exp_col[DW*(PE-k)-1 -: DW] = hd[k][DW*(PE-k)-1 -: DW];
            end
        end
        exp_busy = tile_open || (last_pend && (edge_n - last_edge) < PE - 1);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < PE; k++) begin
            hv[k] = 1'b0;
            hd[k] = '0;
        end
        last_pend = 0;
        tile_open = 0;
        m_cnt     = 0;
        m_done    = 0;
        model_outputs();
    endfunction

    // One clock: drive inputs mid-cycle, predict ready/accept, advance model, sample 1ns after edge.
    task automatic step(input bit v, input logic [VW-1:0] d, input bit l, input bit c);
        in_valid_i = v;
        in_data_i  = d;
        in_last_i  = l;
        clear_i    = c;
        #1;
        obs_ready = in_ready_o;
        m_ready   = !c && !(last_pend && (edge_n + 1 - last_edge) <= PE - 1);
        m_acc     = v && m_ready;
        @(posedge clk);
        edge_n++;
        if (c) begin
            model_reset();
        end else begin
            m_done = last_pend && (edge_n - last_edge == PE - 1);
            if (m_done) last_pend = 0;
            for (int k = PE - 1; k > 0; k--) begin
                hv[k] = hv[k-1];
                hd[k] = hd[k-1];
            end
            hv[0] = m_acc;
            hd[0] = m_acc ? d : '0;
            if (m_acc) begin
                m_cnt     = tile_open ? ((m_cnt == 65535) ? 65535 : m_cnt + 1) : 1;
                tile_open = !l;
                if (l) begin
                    last_pend = 1;
                    last_edge = edge_n;
                end
            end
            model_outputs();
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (weight_col_o !== '0 || weight_en_col_o !== '0) begin n_fail++; $display("FAIL reset_bus: got %h/%b want 0/0", weight_col_o, weight_en_col_o); end
        n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== 18'd0) begin n_fail++; $display("FAIL reset_status: got busy %b done %b cnt %0d want 0 0 0", busy_o, done_o, beat_cnt_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready_o); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({busy_o, done_o, beat_cnt_o, weight_en_col_o} !== 22'd0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release: got busy %b done %b cnt %0d en %b rdy %b want 0 0 0 0 1", busy_o, done_o, beat_cnt_o, weight_en_col_o, in_ready_o); end
    endtask

    task automatic test_basic();
        logic [VW-1:0] b;
        for (int c = 1; c <= 9; c++) begin
            b = 32'h01020304 + 32'h10101010 * (c - 1);
            if (c <= 4) step(1, b, c == 4, 0);
            else        step(0, $urandom, 1, 0);
            n_cmp++; if (weight_col_o !== exp_col || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL basic_bus c%0d: got %h/%b want %h/%b", c, weight_col_o, weight_en_col_o, exp_col, exp_en); end
            n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== {exp_busy, m_done, 16'(m_cnt)} || obs_ready !== m_ready) begin n_fail++; $display("FAIL basic_status c%0d: got %b %b %0d rdy %b want %b %b %0d rdy %b", c, busy_o, done_o, beat_cnt_o, obs_ready, exp_busy, m_done, m_cnt, m_ready); end
            if (c <= 4) begin
                n_cmp++; if (weight_col_o[31:24] !== 8'(8'h01 + 16 * (c - 1))) begin n_fail++; $display("FAIL basic_lane0 c%0d: got %h want %h", c, weight_col_o[31:24], 8'(8'h01 + 16 * (c - 1))); end
            end
            if (c >= 4 && c <= 7) begin
                n_cmp++; if (weight_col_o[7:0] !== 8'(8'h04 + 16 * (c - 4))) begin n_fail++; $display("FAIL basic_lane3 c%0d: got %h want %h", c, weight_col_o[7:0], 8'(8'h04 + 16 * (c - 4))); end
            end
            n_cmp++; if (done_o !== (c == 7)) begin n_fail++; $display("FAIL basic_done c%0d: got %b want %b", c, done_o, c == 7); end
        end
        n_cmp++; if (beat_cnt_o !== 16'd4) begin n_fail++; $display("FAIL basic_cnt: got %0d want 4", beat_cnt_o); end
    endtask

    task automatic test_bubble();
        logic [VW-1:0] b;
        int bi;
        bi = 0;
        for (int c = 1; c <= 10; c++) begin
            b = 32'h01020304 + 32'h10101010 * bi;
            if (c == 2 || c > 5) step(0, $urandom, 0, 0);
            else begin step(1, b, bi == 3, 0); bi++; end
            n_cmp++; if (weight_col_o !== exp_col || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL bubble_bus c%0d: got %h/%b want %h/%b", c, weight_col_o, weight_en_col_o, exp_col, exp_en); end
            n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== {exp_busy, m_done, 16'(m_cnt)} || obs_ready !== m_ready) begin n_fail++; $display("FAIL bubble_status c%0d: got %b %b %0d rdy %b want %b %b %0d rdy %b", c, busy_o, done_o, beat_cnt_o, obs_ready, exp_busy, m_done, m_cnt, m_ready); end
            for (int k = 0; k < PE; k++) begin
                if (c == 2 + k) begin
                    n_cmp++; if (weight_en_col_o[PE-1-k] !== 1'b0 || weight_col_o[DW*(PE-k)-1 -: DW] !== 8'h00) begin n_fail++; $display("FAIL bubble_slot lane%0d c%0d: got en %b data %h want 0 00", k, c, weight_en_col_o[PE-1-k], weight_col_o[DW*(PE-k)-1 -: DW]); end
                end
            end
            n_cmp++; if (done_o !== (c == 8)) begin n_fail++; $display("FAIL bubble_done c%0d: got %b want %b", c, done_o, c == 8); end
        end
    endtask

    task automatic test_single_beat();
        int low_cnt;
        low_cnt = 0;
        for (int j = 1; j <= 7; j++) begin
            if (j == 1) step(1, $urandom, 1, 0);
            else        step(0, $urandom, 0, 0);
            if (obs_ready === 1'b0) low_cnt++;
            n_cmp++; if (weight_col_o !== exp_col || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL single_bus j%0d: got %h/%b want %h/%b", j, weight_col_o, weight_en_col_o, exp_col, exp_en); end
            n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== {exp_busy, m_done, 16'(m_cnt)} || obs_ready !== m_ready) begin n_fail++; $display("FAIL single_status j%0d: got %b %b %0d rdy %b want %b %b %0d rdy %b", j, busy_o, done_o, beat_cnt_o, obs_ready, exp_busy, m_done, m_cnt, m_ready); end
            n_cmp++; if (done_o !== (j == 4)) begin n_fail++; $display("FAIL single_done j%0d: got %b want %b", j, done_o, j == 4); end
        end
        n_cmp++; if (low_cnt != 3) begin n_fail++; $display("FAIL single_ready_low: got %0d cycles want 3", low_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] a, b, cc, d;
        a = $urandom; b = $urandom; cc = $urandom; d = $urandom;
        for (int j = 1; j <= 13; j++) begin
            if (j == 1)      step(1, a, 0, 0);
            else if (j == 2) step(1, b, 1, 0);
            else if (j <= 6) step(1, cc, 0, 0);
            else if (j == 7) step(1, d, 1, 0);
            else             step(0, $urandom, 0, 0);
            n_cmp++; if (weight_col_o !== exp_col || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL b2b_bus j%0d: got %h/%b want %h/%b", j, weight_col_o, weight_en_col_o, exp_col, exp_en); end
            n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== {exp_busy, m_done, 16'(m_cnt)} || obs_ready !== m_ready) begin n_fail++; $display("FAIL b2b_status j%0d: got %b %b %0d rdy %b want %b %b %0d rdy %b", j, busy_o, done_o, beat_cnt_o, obs_ready, exp_busy, m_done, m_cnt, m_ready); end
            if (j == 5) begin
                n_cmp++; if (done_o !== 1'b1 || weight_col_o[7:0] !== b[7:0]) begin n_fail++; $display("FAIL b2b_old_lane3: got done %b data %h want 1 %h", done_o, weight_col_o[7:0], b[7:0]); end
            end
            if (j == 6) begin
                n_cmp++; if (obs_ready !== 1'b1 || beat_cnt_o !== 16'd1 || weight_col_o[31:24] !== cc[31:24]) begin n_fail++; $display("FAIL b2b_new_lane0: got rdy %b cnt %0d data %h want 1 1 %h", obs_ready, beat_cnt_o, weight_col_o[31:24], cc[31:24]); end
            end
        end
    endtask

    task automatic test_clear();
        for (int j = 1; j <= 9; j++) begin
            if (j <= 2)      step(1, $urandom, 0, 0);
            else if (j == 3) step(1, $urandom, 1, 1);
            else             step(0, $urandom, 0, 0);
            n_cmp++; if (weight_col_o !== exp_col || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL clear_bus j%0d: got %h/%b want %h/%b", j, weight_col_o, weight_en_col_o, exp_col, exp_en); end
            n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== {exp_busy, m_done, 16'(m_cnt)} || obs_ready !== m_ready) begin n_fail++; $display("FAIL clear_status j%0d: got %b %b %0d rdy %b want %b %b %0d rdy %b", j, busy_o, done_o, beat_cnt_o, obs_ready, exp_busy, m_done, m_cnt, m_ready); end
            if (j == 3) begin
                n_cmp++; if (obs_ready !== 1'b0 || weight_en_col_o !== '0 || busy_o !== 1'b0 || beat_cnt_o !== 16'd0) begin n_fail++; $display("FAIL clear_flush: got rdy %b en %b busy %b cnt %0d want 0 0 0 0", obs_ready, weight_en_col_o, busy_o, beat_cnt_o); end
            end
            if (j >= 3) begin
                n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL clear_no_done j%0d: got %b want 0", j, done_o); end
            end
        end
    endtask

    task automatic test_random();
        bit c;
        for (int i = 0; i < 200; i++) begin
            c = ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 3) == 0, c);
            n_cmp++; if (weight_col_o !== exp_col || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL rand_bus i%0d: got %h/%b want %h/%b", i, weight_col_o, weight_en_col_o, exp_col, exp_en); end
            n_cmp++; if ({busy_o, done_o, beat_cnt_o} !== {exp_busy, m_done, 16'(m_cnt)} || obs_ready !== m_ready) begin n_fail++; $display("FAIL rand_status i%0d: got %b %b %0d rdy %b want %b %b %0d rdy %b", i, busy_o, done_o, beat_cnt_o, obs_ready, exp_busy, m_done, m_cnt, m_ready); end
        end
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
    endtask

    task automatic test_reset_mid_drain();
        step(1, $urandom, 0, 0);
        step(1, $urandom, 1, 0);
        step(0, $urandom, 0, 0);
        n_cmp++; if (busy_o !== 1'b1 || in_ready_o !== 1'b0 || weight_en_col_o === '0) begin n_fail++; $display("FAIL rst_pre_drain: got busy %b rdy %b en %b want 1 0 nonzero", busy_o, in_ready_o, weight_en_col_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (weight_col_o !== '0 || weight_en_col_o !== '0 || {busy_o, done_o, beat_cnt_o} !== 18'd0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_async: got %h/%b busy %b done %b cnt %0d rdy %b want 0/0 0 0 0 1", weight_col_o, weight_en_col_o, busy_o, done_o, beat_cnt_o, in_ready_o); end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 1; j <= 6; j++) begin
            step(0, $urandom, 0, 0);
            n_cmp++; if (done_o !== 1'b0 || obs_ready !== 1'b1 || weight_en_col_o !== exp_en) begin n_fail++; $display("FAIL rst_after j%0d: got done %b rdy %b en %b want 0 1 %b", j, done_o, obs_ready, weight_en_col_o, exp_en); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_single_beat();
        test_back_to_back();
        test_clear();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
